// File: rtl/darkuart_pkg.sv
// darkuart_pkg: shared FSM encoding and darkuart register lane constants.
package darkuart_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL,
    S_WAIT,
    S_WRITE,
    S_SETTLE,
    S_DONE
  } state_t;
  localparam logic [3:0] STATUS_BE = 4'b0001;
  localparam logic [3:0] BUF_BE = 4'b0010;
  localparam int TX_BUSY_BIT = 0;
endpackage

// File: rtl/darkuart_rrarb.sv
// darkuart_rrarb: combinational round-robin pick starting at i_ptr.
// With i_lock set only requesters in i_own are eligible.
module darkuart_rrarb #(
  parameter int NREQ = 4,
  parameter int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  input  logic            i_lock,
  input  logic [NREQ-1:0] i_own,
  output logic [NREQ-1:0] o_win,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);
  logic [NREQ-1:0] w_req;
  logic [IW-1:0] w_j;
  assign w_req = i_lock ? (i_req & i_own) : i_req;
  assign o_any = |w_req;
  assign o_win = o_any ? (NREQ'(1) << o_idx) : '0;
  // Scanning from the farthest offset down leaves the nearest one after i_ptr.
  always_comb begin
    o_idx = '0;
    w_j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_j = IW'((int'(i_ptr) + k) % NREQ);
      if (w_req[w_j]) o_idx = w_j;
    end
  end
endmodule

// File: rtl/darkuart_txarb.sv
// darkuart_txarb: round-robin arbiter sharing the darkuart transmit channel.
// Define UART_ARB_LINELOCK_EN to keep ownership until a LAST byte.
module darkuart_txarb
  import darkuart_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int POLL_GAP = 2
) (
  input  logic              CLK,
  input  logic              RES,
  input  logic [NREQ-1:0]   REQ,
  input  logic [8*NREQ-1:0] DATA,
  input  logic [NREQ-1:0]   LAST,
  output logic [NREQ-1:0]   ACK,
  output logic [NREQ-1:0]   GNT,
  output logic              U_RD,
  output logic              U_WR,
  output logic [3:0]        U_BE,
  output logic [31:0]       U_DO,
  input  logic [31:0]       U_DI
);
  localparam int IW = $clog2(NREQ);
  state_t r_state;
  logic [IW-1:0] r_ptr, r_idx, w_idx, w_nxt;
  logic [NREQ-1:0] r_gnt, r_ack, w_win;
  logic [7:0] r_byte, r_gap;
  logic [3:0] r_be;
  logic [31:0] r_do;
  logic r_lastf, r_rd, r_wr, w_any, w_lock, w_unused;
`ifdef UART_ARB_LINELOCK_EN
  logic r_lock;
  assign w_lock = r_lock & |(REQ & r_gnt);
  assign w_unused = ^U_DI[31:1];
`else
  assign w_lock = 1'b0;
  assign w_unused = ^{U_DI[31:1], r_lastf};
`endif
  assign w_nxt = (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + IW'(1);
  darkuart_rrarb #(.NREQ(NREQ), .IW(IW)) u_arb (
    .i_req (REQ),
    .i_ptr (r_ptr),
    .i_lock(w_lock),
    .i_own (r_gnt),
    .o_win (w_win),
    .o_idx (w_idx),
    .o_any (w_any)
  );
  // Outputs are registered: each transition loads the strobes of the state it enters.
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      r_state <= S_IDLE;
      r_ptr <= '0;
      r_idx <= '0;
      r_gnt <= '0;
      r_ack <= '0;
      r_byte <= '0;
      r_lastf <= 1'b0;
      r_gap <= '0;
      r_rd <= 1'b0;
      r_wr <= 1'b0;
      r_be <= '0;
      r_do <= '0;
`ifdef UART_ARB_LINELOCK_EN
      r_lock <= 1'b0;
`endif
    end else begin
      r_rd <= 1'b0;
      r_wr <= 1'b0;
      r_be <= '0;
      r_do <= '0;
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
`ifdef UART_ARB_LINELOCK_EN
          if (r_lock && !w_lock) begin
            r_lock <= 1'b0;
            r_gnt <= '0;
          end
`endif
          if (w_any) begin
            r_gnt <= w_win;
            r_idx <= w_idx;
            r_byte <= DATA[{w_idx, 3'b000} +: 8];
            r_lastf <= LAST[w_idx];
            r_rd <= 1'b1;
            r_be <= STATUS_BE;
            r_state <= S_POLL;
          end
        end
        S_POLL: begin
          if (U_DI[TX_BUSY_BIT]) begin
            if (POLL_GAP == 0) begin
              r_rd <= 1'b1;
              r_be <= STATUS_BE;
            end else begin
              r_gap <= 8'(POLL_GAP);
              r_state <= S_WAIT;
            end
          end else begin
            r_wr <= 1'b1;
            r_be <= BUF_BE;
            r_do <= {16'h0000, r_byte, 8'h00};
            r_state <= S_WRITE;
          end
        end
        S_WAIT: begin
          r_gap <= r_gap - 8'd1;
          if (r_gap == 8'd1) begin
            r_rd <= 1'b1;
            r_be <= STATUS_BE;
            r_state <= S_POLL;
          end
        end
        S_WRITE: r_state <= S_SETTLE;
        S_SETTLE: begin
          r_ack <= r_gnt;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
`ifdef UART_ARB_LINELOCK_EN
          r_lock <= !r_lastf;
          if (r_lastf) begin
            r_gnt <= '0;
            r_ptr <= w_nxt;
          end
`else
          r_gnt <= '0;
          r_ptr <= w_nxt;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign ACK = r_ack;
  assign GNT = r_gnt;
  assign U_RD = r_rd;
  assign U_WR = r_wr;
  assign U_BE = r_be;
  assign U_DO = r_do;
endmodule

// File: tb/tb_darkuart_txarb.sv
// tb_darkuart_txarb: directed self-checking bench for darkuart_txarb.
// Line-order expectations follow UART_ARB_LINELOCK_EN when it is defined.
module tb_darkuart_txarb;
  logic CLK = 1'b0;
  logic RES = 1'b0;
  logic [3:0] REQ = '0;
  logic [31:0] DATA = '0;
  logic [3:0] LAST = '0;
  logic [3:0] ACK, GNT, U_BE;
  logic U_RD, U_WR;
  logic [31:0] U_DO, U_DI;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int rd_base = 0;
  int busy_n = 0;
  int rd_t[$];
  logic [7:0] wr_q[$];
  int ack_q[$];

  darkuart_txarb #(.NREQ(4), .POLL_GAP(2)) dut (
    .CLK(CLK), .RES(RES), .REQ(REQ), .DATA(DATA), .LAST(LAST),
    .ACK(ACK), .GNT(GNT), .U_RD(U_RD), .U_WR(U_WR), .U_BE(U_BE),
    .U_DO(U_DO), .U_DI(U_DI)
  );

  always #5 CLK = ~CLK;

  // darkuart model: reports busy for the first busy_n polls after rd_base
  assign U_DI = {31'd0, (rd_cnt - rd_base) < busy_n};

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (U_RD) begin
      rd_cnt <= rd_cnt + 1;
      rd_t.push_back(cyc);
    end
    if (U_WR) wr_q.push_back(U_DO[15:8]);
    for (int i = 0; i < 4; i++) if (ACK[i]) ack_q.push_back(i);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack();
    for (int t = 0; t < 60 && ACK == 4'b0; t++) tick();
  endtask

  initial begin
    int rb, wb, ab, n, i0, i1;
    logic [7:0] s1[3];
    logic [7:0] s0[2];
    logic [7:0] exp_b[5];
    // reset state
    tick();
    tick();
    chk("rst_gnt", GNT, 0);
    chk("rst_ack", ACK, 0);
    chk("rst_rd_wr", {U_RD, U_WR}, 0);
    chk("rst_be", U_BE, 0);
    chk("rst_do", U_DO, 0);
    RES = 1'b1;
    tick();
    // single requester, darkuart idle
    REQ = 4'b0001;
    DATA[7:0] = 8'h41;
    tick();
    chk("single_poll_rd", U_RD, 1);
    chk("single_poll_be", U_BE, 4'b0001);
    chk("single_gnt", GNT, 4'b0001);
    tick();
    chk("single_wr", U_WR, 1);
    chk("single_wr_be", U_BE, 4'b0010);
    chk("single_do", U_DO, 32'h0000_4100);
    tick();
    chk("single_settle", {U_WR, U_RD, ACK}, 0);
    tick();
    chk("single_ack", ACK, 4'b0001);
    REQ = 4'b0000;
    tick();
    chk("single_ack_clr", ACK, 0);
    chk("single_gnt_clr", GNT, 0);
    // busy retry: three busy polls
    rb = rd_t.size();
    wb = wr_q.size();
    rd_base = rd_cnt;
    busy_n = 3;
    REQ = 4'b0010;
    DATA[15:8] = 8'h5A;
    wait_ack();
    chk("busy_ack", ACK, 4'b0010);
    REQ = 4'b0000;
    tick();
    busy_n = 0;
    chk("busy_rd_count", rd_t.size() - rb, 4);
    if (rd_t.size() - rb >= 4) begin
      chk("busy_gap1", rd_t[rb+1] - rd_t[rb], 3);
      chk("busy_gap2", rd_t[rb+2] - rd_t[rb+1], 3);
      chk("busy_gap3", rd_t[rb+3] - rd_t[rb+2], 3);
    end
    chk("busy_wr_count", wr_q.size() - wb, 1);
    if (wr_q.size() > wb) chk("busy_wr_byte", wr_q[wb], 8'h5A);
    // round-robin wrap from PTR=0
    RES = 1'b0;
    tick();
    RES = 1'b1;
    tick();
    ab = ack_q.size();
    wb = wr_q.size();
    REQ = 4'b1111;
    DATA = 32'h3322_1100;
    n = 0;
    for (int t = 0; t < 80 && n < 5; t++) begin
      tick();
      if (ACK != 0) n++;
    end
    REQ = 4'b0000;
    tick();
    chk("rr_ack_count", ack_q.size() - ab, 5);
    if (ack_q.size() - ab >= 5) begin
      chk("rr_order0", ack_q[ab], 0);
      chk("rr_order1", ack_q[ab+1], 1);
      chk("rr_order2", ack_q[ab+2], 2);
      chk("rr_order3", ack_q[ab+3], 3);
      chk("rr_order4", ack_q[ab+4], 0);
    end
    if (wr_q.size() - wb >= 4) chk("rr_byte3", wr_q[wb+3], 8'h33);
    // PTR now 1: with requesters 0,2,3 the winner is 2; then 2 withdraws in POLL
    ab = ack_q.size();
    wb = wr_q.size();
    REQ = 4'b1101;
    tick();
    chk("ptr_after_rr", GNT, 4'b0100);
    REQ = 4'b0000;
    wait_ack();
    chk("withdraw_ack", ACK, 4'b0100);
    for (int t = 0; t < 8; t++) tick();
    chk("withdraw_ack_once", ack_q.size() - ab, 1);
    chk("withdraw_wr_count", wr_q.size() - wb, 1);
    if (wr_q.size() > wb) chk("withdraw_byte", wr_q[wb], 8'h22);
    // line of requester 1 against requester 0 (PTR=3)
    s1[0] = 8'h68;
    s1[1] = 8'h69;
    s1[2] = 8'h0A;
    s0[0] = 8'h58;
    s0[1] = 8'h59;
`ifdef UART_ARB_LINELOCK_EN
    exp_b[0] = 8'h68;
    exp_b[1] = 8'h69;
    exp_b[2] = 8'h0A;
    exp_b[3] = 8'h58;
    exp_b[4] = 8'h59;
`else
    exp_b[0] = 8'h68;
    exp_b[1] = 8'h58;
    exp_b[2] = 8'h69;
    exp_b[3] = 8'h59;
    exp_b[4] = 8'h0A;
`endif
    wb = wr_q.size();
    i0 = 0;
    i1 = 0;
    REQ = 4'b0010;
    DATA = {16'h0, s1[0], 8'h00};
    LAST = 4'b0001;
    tick();
    REQ[0] = 1'b1;
    DATA[7:0] = s0[0];
    for (int t = 0; t < 150 && (i1 < 3 || i0 < 2); t++) begin
      tick();
      if (ACK[1]) begin
        i1++;
        if (i1 < 3) begin
          DATA[15:8] = s1[i1];
          LAST[1] = (i1 == 2);
        end else REQ[1] = 1'b0;
      end
      if (ACK[0]) begin
        i0++;
        if (i0 < 2) DATA[7:0] = s0[i0];
        else REQ[0] = 1'b0;
      end
    end
    tick();
    chk("line_wr_count", wr_q.size() - wb, 5);
    if (wr_q.size() - wb >= 5)
      for (int k = 0; k < 5; k++) chk($sformatf("line_byte%0d", k), wr_q[wb+k], exp_b[k]);
    LAST = 4'b0000;
    // reset during WAIT aborts the transfer
    ab = ack_q.size();
    rd_base = rd_cnt;
    busy_n = 1000;
    REQ = 4'b0100;
    DATA[23:16] = 8'h77;
    tick();
    tick();
    chk("abort_wait_rd", U_RD, 0);
    chk("abort_wait_gnt", GNT, 4'b0100);
    RES = 1'b0;
    REQ = 4'b0000;
    tick();
    chk("abort_gnt", GNT, 0);
    chk("abort_strobes", {U_RD, U_WR, U_BE}, 0);
    chk("abort_ack", ACK, 0);
    busy_n = 0;
    REQ = 4'b1000;
    DATA[31:24] = 8'h33;
    RES = 1'b1;
    tick();
    chk("post_reset_gnt", GNT, 4'b1000);
    wait_ack();
    chk("post_reset_ack", ACK, 4'b1000);
    REQ = 4'b0000;
    tick();
    chk("abort_no_stray_ack", ack_q.size() - ab, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/darkuart_txarb.md
# darkuart_txarb

Round-robin transmit arbiter that shares the single darkuart transmit channel among NREQ byte producers (core console, debug monitor, boot loader). It sits between the requesters and the darkuart bus port and drives that port's RD/WR/BE/DATAI signals itself. For each granted byte it polls the darkuart status byte until the transmitter is idle, writes the byte into the buffer register, then acknowledges the requester.

## Interface
- NREQ, 4: number of requesters, 2..8.
- POLL_GAP, 2: idle cycles between a status read that returns busy and the next status read, 0..255.
- CLK  in  1  clock.
- RES  in  1  asynchronous, active-low reset.
- REQ  in  NREQ  per-requester byte request; level, held until ACK.
- DATA  in  8*NREQ  byte of requester i on DATA[8i+7:8i].
- LAST  in  NREQ  byte is end of line; used only with UART_ARB_LINELOCK_EN.
- ACK  out  NREQ  one-cycle pulse: byte handed to darkuart.
- GNT  out  NREQ  one-hot, current owner; all zero when idle.
- U_RD  out  1  darkuart RD.
- U_WR  out  1  darkuart WR.
- U_BE  out  4  darkuart BE.
- U_DO  out  32  to darkuart DATAI; byte on [15:8], other bits 0.
- U_DI  in  32  from darkuart DATAO; bit 0 = transmit busy.

## Operation
- States: IDLE, POLL, WAIT, WRITE, SETTLE, DONE.
- IDLE: if any REQ is set, choose the winner round-robin, searching from PTR upward with modulo-NREQ wrap. Latch its DATA and LAST into BYTE and LASTF, set GNT, go to POLL.
- POLL: U_RD=1, U_BE=4'b0001. Sample U_DI[0] in the same cycle.
  - Busy: go to WAIT and load the gap counter with POLL_GAP.
  - Idle: go to WRITE.
- WAIT: decrement the gap counter; go to POLL when it is 0. A POLL_GAP of 0 goes straight back to POLL.
- WRITE: U_WR=1, U_BE=4'b0010, U_DO[15:8]=BYTE. Go to SETTLE.
- SETTLE: one dead cycle so the darkuart busy flag can update before any further poll. Go to DONE.
- DONE: pulse ACK for the owner. PTR becomes owner+1 (mod NREQ), GNT clears, go to IDLE.
- The byte is latched at grant. If REQ drops after grant, the transfer still completes and ACK still pulses.
- A requester must see ACK before it presents its next byte. REQ still high in the cycle after ACK counts as a new request.
- U_RD, U_WR and U_BE are 0 outside POLL and WRITE. U_DO is 0 outside WRITE.
- Reset: all outputs 0, PTR=0, state IDLE, gap counter 0, BYTE 0.
- Reset asserted mid-transfer aborts the transfer with no ACK. If reset falls on a WRITE cycle, that darkuart write is dropped.

## Timing
- Minimum byte cost from REQ rising to ACK, darkuart idle: 5 cycles (IDLE, POLL, WRITE, SETTLE, DONE). ACK is high in cycle 5.
- A busy poll adds 1+POLL_GAP cycles per retry.
- Back-to-back bytes: the next grant is in the cycle after DONE.
- With N requesters continuously active, each is served once every N grants. No requester starves.

## Configuration
- UART_ARB_LINELOCK_EN defined:
  - In DONE, if LASTF=0 the owner keeps GNT and PTR is unchanged.
  - The next arbitration considers only that owner while its REQ is high.
  - If the owner's REQ is low in IDLE, the lock is released and normal round-robin resumes.
  - A byte with LAST=1 releases the lock and advances PTR.
  - Effect: lines from different producers are never interleaved.
- Undefined: LAST is ignored; arbitration runs per byte.

## Structure
- Shared package darkuart_pkg holds:
  - the FSM state encoding;
  - darkuart register byte lanes (STATUS_BE=4'b0001, BUF_BE=4'b0010);
  - the status bit index TX_BUSY_BIT=0.
- Sub-module darkuart_rrarb: combinational round-robin priority pick from REQ and PTR, plus the lock mask. It returns a one-hot winner and its index.

## Test plan
- Single requester: REQ[0]=1, DATA="A" (8'h41), U_DI[0]=0 → U_WR in cycle 3 with U_DO=32'h0000_4100, ACK[0] in cycle 5.
- Busy retry: U_DI[0]=1 for the first 3 polls, POLL_GAP=2 → exactly 4 U_RD pulses, each 3 cycles apart, then one U_WR.
- Round-robin wrap: REQ=4'b1111 held, PTR=0 → ACK order 0,1,2,3,0; PTR ends at 1.
- REQ withdrawn: REQ[2] drops in POLL → byte still written, ACK[2] pulses once.
- Line lock (macro on): requester 1 sends "hi\n" with LAST on '\n' while REQ[0] stays high → written bytes 'h','i','\n', then requester 0's byte. Macro off: bytes interleave 1,0,1,0,1.
- Reset mid-transfer: RES low during WAIT → all outputs 0 next edge, no ACK. After release with REQ[3]=1 → grant to 3 from PTR=0.
